// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the decode-stage branch resolver and any later
// resolver that reuses the condition evaluator:
//   - width of the branch condition field
//   - condition code encodings (EQC_*)
//   - resolver FSM state encoding
//   - helpers telling which operands a condition actually reads
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

   localparam int COND_W = 4;

   typedef logic [COND_W-1:0] cond_t;

   // Codes 8..15 are undefined and evaluate as not taken.
   localparam cond_t EQC_NONE       = 4'd0;  // never taken
   localparam cond_t EQC_EQUAL      = 4'd1;  // A == B
   localparam cond_t EQC_NOT_EQUAL  = 4'd2;  // A != B
   localparam cond_t EQC_HIGH_EQUAL = 4'd3;  // A >= 0
   localparam cond_t EQC_HIGH       = 4'd4;  // A >  0
   localparam cond_t EQC_LOW_EQUAL  = 4'd5;  // A <= 0
   localparam cond_t EQC_LOW        = 4'd6;  // A <  0
   localparam cond_t EQC_J          = 4'd7;  // always taken

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_OPND = 2'd1,
      ST_REDIRECT  = 2'd2
   } brs_state_e;

   // Operand A feeds every compare; J and NONE read no operand at all.
   function automatic logic cond_uses_a(input cond_t cond);
      return cond inside {EQC_EQUAL, EQC_NOT_EQUAL, EQC_HIGH_EQUAL,
                          EQC_HIGH, EQC_LOW_EQUAL, EQC_LOW};
   endfunction

   // Only the two-operand compares read operand B.
   function automatic logic cond_uses_b(input cond_t cond);
      return cond inside {EQC_EQUAL, EQC_NOT_EQUAL};
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator.
//   op_a, op_b : selected operands (DATA_W bits, two's complement)
//   cond       : condition code (EQC_* encodings)
//   result     : 1 when the branch is taken
// -----------------------------------------------------------------------------
module branch_cond_eval
   import branch_resolve_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  cond_t             cond,
   output logic              result
);

   logic a_neg;
   logic a_zero;

   // Sign-against-zero tests only need the MSB and a zero detect, no adder.
   assign a_neg  = op_a[DATA_W-1];
   assign a_zero = (op_a == '0);

   always_comb begin
      result = 1'b0;
      case (cond)
         EQC_EQUAL:      result = (op_a == op_b);
         EQC_NOT_EQUAL:  result = (op_a != op_b);
         EQC_HIGH_EQUAL: result = !a_neg;
         EQC_HIGH:       result = !a_neg && !a_zero;
         EQC_LOW_EQUAL:  result = a_neg || a_zero;
         EQC_LOW:        result = a_neg;
         EQC_J:          result = 1'b1;
         default:        result = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Decode-stage branch resolution: operand forwarding select, condition
// evaluation, load-use stall, registered redirect to fetch (valid/ready) and
// saturating branch/taken statistics.
// Ports:
//   clock, reset (async, active low), flush (sync, highest priority)
//   id_valid/id_cond/id_rs_val/id_rt_val/id_target : branch in ID
//   fwd_sel_a/b, fwd_data, fwd_pend_a/b            : forwarding network
//   id_stall                                       : hold IF/ID this cycle
//   taken                                          : last resolved outcome
//   redirect_valid/redirect_ready/redirect_pc      : redirect to fetch
//   branch_cnt, taken_cnt                          : saturating statistics
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2,
   parameter int SEL_W   = 2,   // 2**SEL_W must exceed NUM_FWD
   parameter int CNT_W   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      id_valid,
   input  logic [COND_W-1:0]         id_cond,
   input  logic [DATA_W-1:0]         id_rs_val,
   input  logic [DATA_W-1:0]         id_rt_val,
   input  logic [DATA_W-1:0]         id_target,
   input  logic [SEL_W-1:0]          fwd_sel_a,
   input  logic [SEL_W-1:0]          fwd_sel_b,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   input  logic                      fwd_pend_a,
   input  logic                      fwd_pend_b,
   output logic                      id_stall,
   output logic                      taken,
   output logic                      redirect_valid,
   input  logic                      redirect_ready,
   output logic [DATA_W-1:0]         redirect_pc,
   output logic [CNT_W-1:0]          branch_cnt,
   output logic [CNT_W-1:0]          taken_cnt
);

   brs_state_e        state_q, state_d;
   logic              taken_q, taken_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic              cond_result;
   logic              pending;
   logic              resolve;

   // Select 0 and any select beyond NUM_FWD both read the register file.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first so no
      // path leaves it unassigned, which would infer a latch.
      opnd_a = id_rs_val;
      opnd_b = id_rt_val;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (fwd_sel_a == SEL_W'(k)) opnd_a = fwd_data[(k-1)*DATA_W +: DATA_W];
         if (fwd_sel_b == SEL_W'(k)) opnd_b = fwd_data[(k-1)*DATA_W +: DATA_W];
      end
   end

   branch_cond_eval #(
      .DATA_W (DATA_W)
   ) u_cond_eval (
      .op_a   (opnd_a),
      .op_b   (opnd_b),
      .cond   (id_cond),
      .result (cond_result)
   );

   // A pending producer only matters if the condition actually reads it.
   assign pending = (fwd_pend_a && cond_uses_a(id_cond)) ||
                    (fwd_pend_b && cond_uses_b(id_cond));

   always_comb begin
      state_d          = state_q;
      taken_d          = taken_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      branch_cnt_d     = branch_cnt_q;
      taken_cnt_d      = taken_cnt_q;
      id_stall         = 1'b0;
      resolve          = 1'b0;

      if (flush) begin
         // Flush kills the ID instruction and any outstanding redirect;
         // statistics and the last outcome are left alone.
         state_d          = ST_IDLE;
         redirect_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (id_valid) begin
                  if (pending) begin
                     state_d  = ST_WAIT_OPND;
                     id_stall = 1'b1;
                  end else begin
                     resolve = 1'b1;
                  end
               end
            end
            ST_WAIT_OPND: begin
               // Losing id_valid while waiting abandons the branch uncounted.
               if (!id_valid)    state_d  = ST_IDLE;
               else if (pending) id_stall = 1'b1;
               else              resolve  = 1'b1;
            end
            ST_REDIRECT: begin
               // A new branch waits until fetch has taken the current redirect;
               // it is evaluated from IDLE in the cycle after the handshake.
               id_stall = id_valid;
               if (redirect_ready) begin
                  redirect_valid_d = 1'b0;
                  state_d          = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (resolve) begin
            taken_d      = cond_result;
            branch_cnt_d = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + CNT_W'(1);
            if (cond_result) begin
               taken_cnt_d      = (taken_cnt_q == '1) ? taken_cnt_q : taken_cnt_q + CNT_W'(1);
               redirect_pc_d    = id_target;
               redirect_valid_d = 1'b1;
               state_d          = ST_REDIRECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         taken_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         branch_cnt_q     <= '0;
         taken_cnt_q      <= '0;
      end else begin
         state_q          <= state_d;
         taken_q          <= taken_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         branch_cnt_q     <= branch_cnt_d;
         taken_cnt_q      <= taken_cnt_d;
      end
   end

   assign taken          = taken_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign branch_cnt     = branch_cnt_q;
   assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed and randomized stimulus for branch_resolve_unit (CNT_W=4 so that
// counter saturation is reachable quickly), checked against a behavioural
// model of the resolver kept in this file.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   localparam int DATA_W  = 32;
   localparam int NUM_FWD = 2;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                      clock;
   logic                      reset;
   logic                      flush;
   logic                      id_valid;
   logic [COND_W-1:0]         id_cond;
   logic [DATA_W-1:0]         id_rs_val;
   logic [DATA_W-1:0]         id_rt_val;
   logic [DATA_W-1:0]         id_target;
   logic [SEL_W-1:0]          fwd_sel_a;
   logic [SEL_W-1:0]          fwd_sel_b;
   logic [DATA_W-1:0]         fwd [NUM_FWD];
   logic [NUM_FWD*DATA_W-1:0] fwd_data;
   logic                      fwd_pend_a;
   logic                      fwd_pend_b;
   logic                      id_stall;
   logic                      taken;
   logic                      redirect_valid;
   logic                      redirect_ready;
   logic [DATA_W-1:0]         redirect_pc;
   logic [CNT_W-1:0]          branch_cnt;
   logic [CNT_W-1:0]          taken_cnt;

   assign fwd_data = {fwd[1], fwd[0]};

   branch_resolve_unit #(
      .DATA_W  (DATA_W),
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_cond        (id_cond),
      .id_rs_val      (id_rs_val),
      .id_rt_val      (id_rt_val),
      .id_target      (id_target),
      .fwd_sel_a      (fwd_sel_a),
      .fwd_sel_b      (fwd_sel_b),
      .fwd_data       (fwd_data),
      .fwd_pend_a     (fwd_pend_a),
      .fwd_pend_b     (fwd_pend_b),
      .id_stall       (id_stall),
      .taken          (taken),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .branch_cnt     (branch_cnt),
      .taken_cnt      (taken_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   bit          m_waiting;      // branch held in ID for an operand
   bit          m_redirecting;  // redirect offered to fetch
   bit          m_taken;
   int          m_branches;     // true totals; outputs saturate
   int          m_takens;
   logic [31:0] m_rpc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sat(input int n);
      return (n > CNT_MAX) ? 64'(CNT_MAX) : 64'(n);
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
      if (sel >= 1 && sel <= NUM_FWD) return fwd[sel - 1];
      return rf;
   endfunction

   function automatic bit ref_uses_a(input logic [3:0] c);
      return (c >= 1) && (c <= 6);
   endfunction

   function automatic bit ref_uses_b(input logic [3:0] c);
      return (c == 1) || (c == 2);
   endfunction

   function automatic bit ref_cond(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'd1:    return a == b;
         4'd2:    return a != b;
         4'd3:    return $signed(a) >= 0;
         4'd4:    return $signed(a) > 0;
         4'd5:    return $signed(a) <= 0;
         4'd6:    return $signed(a) < 0;
         4'd7:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_regs(input string pfx);
      check({pfx, "_taken"}, taken, m_taken);
      check({pfx, "_rvalid"}, redirect_valid, m_redirecting);
      check({pfx, "_rpc"}, redirect_pc, m_rpc);
      check({pfx, "_bcnt"}, branch_cnt, sat(m_branches));
      check({pfx, "_tcnt"}, taken_cnt, sat(m_takens));
   endtask

   // One clock cycle; entered just after a falling edge with inputs applied.
   task automatic cyc();
      bit          exp_stall, do_res, pend, res;
      logic [31:0] a, b;
      #1;
      a    = pick(fwd_sel_a, id_rs_val);
      b    = pick(fwd_sel_b, id_rt_val);
      pend = (fwd_pend_a && ref_uses_a(id_cond)) || (fwd_pend_b && ref_uses_b(id_cond));
      res  = ref_cond(id_cond, a, b);
      exp_stall = 1'b0;
      do_res    = 1'b0;
      if (flush) begin
         m_waiting     = 1'b0;
         m_redirecting = 1'b0;
      end else begin
         if (m_redirecting) begin
            exp_stall = id_valid;
            if (redirect_ready) m_redirecting = 1'b0;
         end else if (m_waiting) begin
            if (!id_valid) m_waiting = 1'b0;
            else if (pend) exp_stall = 1'b1;
            else do_res = 1'b1;
         end else if (id_valid) begin
            if (pend) begin
               m_waiting = 1'b1;
               exp_stall = 1'b1;
            end else do_res = 1'b1;
         end
         if (do_res) begin
            m_waiting = 1'b0;
            m_taken   = res;
            m_branches++;
            if (res) begin
               m_takens++;
               m_rpc         = id_target;
               m_redirecting = 1'b1;
            end
         end
         check("id_stall", id_stall, exp_stall);
      end
      @(posedge clock);
      #1;
      check_regs("post");
      @(negedge clock);
   endtask

   task automatic idle(input logic ready);
      id_valid       = 1'b0;
      fwd_pend_a     = 1'b0;
      fwd_pend_b     = 1'b0;
      flush          = 1'b0;
      redirect_ready = ready;
   endtask

   task automatic br(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [31:0] tgt);
      id_valid  = 1'b1;
      id_cond   = c;
      id_rs_val = a;
      id_rt_val = b;
      fwd_sel_a = sa;
      fwd_sel_b = sb;
      id_target = tgt;
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic hard_reset();
      idle(1'b0);
      reset = 1'b0;
      #1;
      m_waiting     = 1'b0;
      m_redirecting = 1'b0;
      m_taken       = 1'b0;
      m_branches    = 0;
      m_takens      = 0;
      m_rpc         = '0;
      check_regs("rst");
      check("rst_stall", id_stall, 1'b0);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      fwd[0] = '0;
      fwd[1] = '0;
      idle(1'b0);
      br(EQC_NONE, 0, 0, 0, 0, 0);
      id_valid = 1'b0;
      @(negedge clock);
      hard_reset();

      // Taken EQ from the register file, redirect one cycle later.
      br(EQC_EQUAL, 32'h1234, 32'h1234, 2'd0, 2'd0, 32'h0000_0400);
      cyc();
      check("eq_rvalid", redirect_valid, 1'b1);
      check("eq_rpc", redirect_pc, 32'h0000_0400);
      check("eq_bcnt", branch_cnt, 4'd1);
      check("eq_tcnt", taken_cnt, 4'd1);
      idle(1'b1);
      cyc();
      check("eq_rvalid_drop", redirect_valid, 1'b0);

      // NE with operand A forwarded from source 1, pending for two cycles.
      fwd[0] = 32'd5;
      br(EQC_NOT_EQUAL, 32'd99, 32'd5, 2'd1, 2'd0, 32'h0000_0800);
      fwd_pend_a = 1'b1;
      cyc();
      cyc();
      fwd_pend_a = 1'b0;
      cyc();
      check("ne_not_taken", taken, 1'b0);
      check("ne_no_redirect", redirect_valid, 1'b0);
      idle(1'b0);
      cyc();

      // J held by fetch for three cycles while another branch waits.
      br(EQC_J, 0, 0, 0, 0, 32'h0000_1000);
      cyc();
      br(EQC_EQUAL, 32'd7, 32'd7, 0, 0, 32'h0000_2000);
      redirect_ready = 1'b0;
      repeat (3) cyc();
      check("j_hold_pc", redirect_pc, 32'h0000_1000);
      redirect_ready = 1'b1;
      cyc();                    // handshake, second branch still stalled
      redirect_ready = 1'b0;
      cyc();                    // second branch resolves from IDLE
      check("j_second_pc", redirect_pc, 32'h0000_2000);
      idle(1'b1);
      cyc();

      // Sign tests around zero and the most negative value.
      idle(1'b1);
      br(EQC_HIGH, 32'h0, 0, 0, 0, 32'h0000_3000);
      cyc();
      check("gtz_zero", taken, 1'b0);
      br(EQC_LOW_EQUAL, 32'h8000_0000, 0, 0, 0, 32'h0000_3004);
      cyc();
      check("lez_neg", taken, 1'b1);
      idle(1'b1);
      cyc();
      br(EQC_HIGH, 32'h1, 0, 0, 0, 32'h0000_3008);
      cyc();
      check("gtz_one", taken, 1'b1);
      idle(1'b1);
      cyc();

      // Flush while redirecting and while waiting for an operand.
      br(EQC_J, 0, 0, 0, 0, 32'h0000_4000);
      redirect_ready = 1'b0;
      cyc();
      idle(1'b0);
      flush = 1'b1;
      cyc();
      check("flush_redir", redirect_valid, 1'b0);
      flush = 1'b0;
      br(EQC_EQUAL, 32'd3, 32'd3, 2'd2, 2'd0, 32'h0000_5000);
      fwd_pend_a = 1'b1;
      cyc();
      flush = 1'b1;
      cyc();
      idle(1'b0);
      cyc();

      // Saturation: 17 taken branches on a 4-bit counter.
      hard_reset();
      repeat (17) begin
         br(EQC_J, 0, 0, 0, 0, $urandom);
         redirect_ready = 1'b0;
         cyc();
         idle(1'b1);
         cyc();
      end
      check("sat_bcnt", branch_cnt, 4'd15);
      check("sat_tcnt", taken_cnt, 4'd15);
      br(EQC_J, 0, 0, 0, 0, 32'h0000_6000);
      redirect_ready = 1'b0;
      cyc();
      hard_reset();             // mid-redirect

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if (i % 250 == 249) hard_reset();
         id_valid       = ($urandom_range(0, 2) != 0);
         id_cond        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                                      : 4'($urandom_range(0, 7));
         id_rs_val      = rand_val();
         id_rt_val      = ($urandom_range(0, 2) == 0) ? id_rs_val : rand_val();
         id_target      = $urandom;
         fwd[0]         = ($urandom_range(0, 2) == 0) ? id_rt_val : rand_val();
         fwd[1]         = rand_val();
         fwd_sel_a      = 2'($urandom_range(0, 3));
         fwd_sel_b      = 2'($urandom_range(0, 3));
         fwd_pend_a     = ($urandom_range(0, 3) == 0);
         fwd_pend_b     = ($urandom_range(0, 3) == 0);
         redirect_ready = 1'($urandom_range(0, 1));
         flush          = ($urandom_range(0, 31) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Decode-stage branch resolution unit and next generation of the combinational equal/compare block.
- Selects each branch operand from the register file or one of NUM_FWD forwarding sources.
- Evaluates the branch condition and waits, with a stall, while a forwarded operand is still pending (load-use).
- Issues a registered redirect to fetch over a valid/ready handshake.
- Keeps saturating branch and taken statistics.
- Sits between the register file/forwarding network and the fetch PC mux.

Parameters:
DATA_W, 32, operand, PC and target width
NUM_FWD, 2, number of forwarding sources (index 1 = nearest stage, e.g. M; index 2 = W)
SEL_W, 2, forwarding select width; must satisfy 2**SEL_W > NUM_FWD
CNT_W, 16, statistics counter width

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush (exception/eret)
id_valid  in  1  branch/jump instruction present in ID
id_cond  in  4  condition code, encodings from shared package
id_rs_val  in  DATA_W  register-file operand A
id_rt_val  in  DATA_W  register-file operand B
id_target  in  DATA_W  precomputed branch/jump target
fwd_sel_a  in  SEL_W  0 = register file; k = forwarding source k
fwd_sel_b  in  SEL_W  same, for operand B
fwd_data  in  NUM_FWD*DATA_W  forwarding values, source k in slice k-1
fwd_pend_a  in  1  operand A producer result not yet available
fwd_pend_b  in  1  operand B producer result not yet available
id_stall  out  1  hold ID/IF this cycle
taken  out  1  registered outcome of last resolved branch
redirect_valid  out  1  redirect request to fetch
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  DATA_W  redirect target
branch_cnt  out  CNT_W  resolved branches, saturating
taken_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Reset (reset low, asynchronous): state IDLE; redirect_valid 0, redirect_pc 0, taken 0, branch_cnt 0, taken_cnt 0.
- Operand select: sel 0 gives id_*_val; sel 1..NUM_FWD gives the fwd_data slice; sel > NUM_FWD falls back to the register file.
- Condition evaluation uses the selected operands:
  - NONE: never taken.
  - EQ: A==B. NE: A!=B.
  - GEZ: A[MSB]==0. GTZ: A[MSB]==0 and A!=0.
  - LEZ: A[MSB]==1 or A==0. LTZ: A[MSB]==1.
  - J: always taken.
  - Undefined codes: not taken.
- pending = (fwd_pend_a and operand A used) or (fwd_pend_b and operand B used). Operand B is used only by EQ/NE; J/NONE use neither operand.
- FSM states: IDLE, WAIT_OPND, REDIRECT.
- IDLE:
  - id_valid and pending: go to WAIT_OPND; id_stall=1.
  - id_valid and not pending: resolve this cycle; id_stall=0.
  - Resolve means: taken<=result; branch_cnt+1; if result, taken_cnt+1, redirect_pc<=id_target, redirect_valid<=1, go to REDIRECT; otherwise stay IDLE.
- WAIT_OPND:
  - id_stall=1 while pending.
  - First cycle with pending=0: resolve as in IDLE, id_stall=0.
  - id_valid dropping here is illegal; the FSM returns to IDLE without counting.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready.
  - The handshake cycle clears redirect_valid and returns to IDLE.
  - The delay-slot instruction proceeds normally (non-branch, id_valid=0).
  - id_valid=1 in REDIRECT forces id_stall=1; that branch is evaluated in the cycle after the handshake.
- Redirect latency: one cycle from the resolving edge to redirect_valid=1. Best-case taken branch gives a redirect on cycle N+1.
- flush has highest priority: next state IDLE, redirect_valid<=0, nothing resolves that cycle. Counters and taken keep their values.
- Counters saturate at all-ones and do not wrap.
- Asynchronous reset mid-redirect drops redirect_valid immediately.

Decomposition:
- Shared defines package holds:
  - condition encodings EQC_NONE/EQUAL/NOT_EQUAL/HIGH_EQUAL/HIGH/LOW_EQUAL/LOW/J;
  - the 4-bit condition field width;
  - FSM state encodings.
- One sub-module, branch_cond_eval: purely combinational (operands, cond) -> result, reusable by a later EX-stage resolver.
- Operand muxing and the FSM stay in the top level.

Test Plan:
- EQ, sel 0/0, rs=rt=0x1234, no pending -> id_stall=0; next cycle redirect_valid=1, redirect_pc=id_target, taken=1, branch_cnt=1, taken_cnt=1; ready=1 -> valid drops next cycle.
- NE, sel_a=1 fwd0=5, rt=5, fwd_pend_a=1 for 2 cycles -> id_stall=1 for 2 cycles, resolves on the 3rd, not taken, branch_cnt=1, taken_cnt=0, no redirect.
- J with redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable for 4 cycles, clear after the handshake; a second id_valid stays stalled until then.
- GTZ with A=0, then A=0x80000000 with LEZ, then A=1 with GTZ -> not taken, taken, taken.
- flush asserted in REDIRECT and in WAIT_OPND -> state IDLE, redirect_valid=0 next cycle, counters unchanged.
- CNT_W=4, 17 taken branches -> branch_cnt=taken_cnt=15 (saturated); reset low mid-sequence -> all outputs 0 immediately.
